// File: rtl/timer_csr_if.sv
// timer_csr_if: request/ready register bus between a CPU-side initiator and the timer.
interface timer_csr_if #(parameter int N = 32);
  logic         sel;
  logic         we;
  logic [1:0]   addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         ready;
  modport master(output sel, we, addr, wdata, input rdata, ready);
  modport slave(input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/timer_csr.sv
// timer_csr: memory-mapped prescaled timer with compare match, sticky W1C flag and level irq.
module timer_csr #(
  parameter int N  = 32,
  parameter int PW = 8
) (
  input  logic       clk,
  input  logic       reset,
  timer_csr_if.slave bus,
  output logic       irq
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t         state_q, state_d;
  logic           en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d, ready_q, ready_d;
  logic [PW-1:0]  ps_q, ps_d, pre_q, pre_d;
  logic [N-1:0]   cnt_q, cnt_d, cmp_q, cmp_d, rdata_q, rdata_d, rd_val;
  logic           acc, wr, tick, hit;
  always_comb begin
    acc     = state_q == IDLE && bus.sel;
    wr      = acc && bus.we;
    tick    = en_q && pre_q == ps_q;
    hit     = cnt_q == cmp_q;
    rd_val  = bus.addr == 2'd0 ? N'({ps_q, 5'b0, ie_q, ar_q, en_q}) :
              bus.addr == 2'd1 ? cnt_q :
              bus.addr == 2'd2 ? cmp_q : N'(match_q);
    state_d = acc ? ACK : IDLE;
    ready_d = acc;
    rdata_d = acc && !bus.we ? rd_val : '0;
    {ie_d, ar_d, en_d} = wr && bus.addr == 2'd0 ? bus.wdata[2:0] : {ie_q, ar_q, en_q};
    ps_d    = wr && bus.addr == 2'd0 ? bus.wdata[PW+7:8] : ps_q;
    cmp_d   = wr && bus.addr == 2'd2 ? bus.wdata : cmp_q;
    // CTRL and COUNT writes both restart the prescaler phase
    pre_d   = wr && !bus.addr[1] ? '0 : !en_q ? pre_q : tick ? '0 : pre_q + PW'(1);
    cnt_d   = wr && bus.addr == 2'd1 ? bus.wdata :
              !tick ? cnt_q : hit && ar_q ? '0 : cnt_q + N'(1);
    match_d = (tick && hit) || (match_q && !(wr && bus.addr == 2'd3 && bus.wdata[0]));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      ps_q    <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      ps_q    <= ps_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = match_q & ie_q;
endmodule

// File: tb/tb_timer_csr.sv
// tb_timer_csr: directed vector table, hand-timed corner sequences and a random run scored against a register-level model.
module tb_timer_csr;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  timer_csr_if #(.N(32)) bus();
  timer_csr #(.N(32), .PW(8)) dut(.clk(clk), .reset(reset), .bus(bus), .irq(irq));
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en, ar, ie, match, ready;
    logic [7:0]  ps, pre;
    logic [31:0] cnt, cmp, rdata;
  } model_t;
  model_t m;

  function automatic model_t reset_state();
    model_t r = '0;
    r.cmp = '1;
    return r;
  endfunction

  // One clock of the timer as described by its register rules.
  function automatic model_t step(model_t s, logic sel, logic we, logic [1:0] a, logic [31:0] wd);
    model_t      n = s;
    bit          access = sel && !s.ready;
    bit          tick = s.en && s.pre == s.ps;
    bit          hit = tick && s.cnt == s.cmp;
    logic [31:0] regs [4];
    regs[0] = {16'h0, s.ps, 5'h0, s.ie, s.ar, s.en};
    regs[1] = s.cnt;
    regs[2] = s.cmp;
    regs[3] = {31'h0, s.match};
    if (s.en) n.pre = tick ? 8'd0 : s.pre + 8'd1;
    if (tick) n.cnt = (hit && s.ar) ? 32'd0 : s.cnt + 32'd1;
    if (hit) n.match = 1'b1;
    n.ready = access;
    n.rdata = (access && !we) ? regs[a] : 32'd0;
    if (access && we)
      case (a)
        2'd0: begin {n.ie, n.ar, n.en} = wd[2:0]; n.ps = wd[15:8]; n.pre = 8'd0; end
        2'd1: begin n.cnt = wd; n.pre = 8'd0; end
        2'd2: n.cmp = wd;
        default: if (wd[0] && !hit) n.match = 1'b0;
      endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) m <= reset_state();
    else m <= step(m, bus.sel, bus.we, bus.addr, bus.wdata);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      check("model ready", {31'h0, bus.ready}, {31'h0, m.ready});
      check("model rdata", bus.rdata, m.rdata);
      check("model irq", {31'h0, irq}, {31'h0, m.match & m.ie});
    end

  // Called just after a negedge; returns at a negedge two cycles later.
  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] exp, input string nm);
    bus.sel = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); @(negedge clk);
    check({nm, " ready"}, {31'h0, bus.ready}, 32'd1);
    if (chk) check(nm, bus.rdata, exp);
    bus.sel = 1'b0; bus.we = 1'b0;
    @(posedge clk); @(negedge clk);
    check({nm, " ready_fall"}, {31'h0, bus.ready}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    access(1'b1, a, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    access(1'b0, a, 32'd0, 1'b1, exp, nm);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0};
    tbl[1]  = '{1'b0, 2'd1, 32'h0,         1'b1, 32'h0};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b1, 2'd2, 32'h1234,      1'b0, 32'h0};
    tbl[5]  = '{1'b0, 2'd2, 32'h0,         1'b1, 32'h1234};
    tbl[6]  = '{1'b1, 2'd0, 32'hFFFF_FFFE, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,         1'b1, 32'h0000_FF06};
    tbl[8]  = '{1'b1, 2'd1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 2'd1, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[10] = '{1'b1, 2'd3, 32'h1,         1'b0, 32'h0};
    tbl[11] = '{1'b0, 2'd3, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{1'b1, 2'd0, 32'h0,         1'b0, 32'h0};
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("irq at reset", {31'h0, irq}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++)
      access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));

    // auto-reload: CMP=3, PRESCALE=0, match every 4 cycles
    wr(2'd2, 32'd3); wr(2'd1, 32'd0); wr(2'd3, 32'd1); wr(2'd0, 32'h7);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ar irq c%0d", i), {31'h0, irq}, {31'h0, i == 4});
      if (i < 4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    wr(2'd3, 32'd1);
    check("w1c vs tick irq", {31'h0, irq}, 32'd1);
    wr(2'd3, 32'd1);
    check("w1c clear irq", {31'h0, irq}, 32'd0);
    rd(2'd3, 32'd0, "w1c status");
    check("rematch irq", {31'h0, irq}, 32'd1);

    // wrap through all-ones, match only at CMP=5
    wr(2'd0, 32'd0); wr(2'd2, 32'd5); wr(2'd1, 32'hFFFF_FFFE); wr(2'd3, 32'd1); wr(2'd0, 32'd1);
    rd(2'd3, 32'd0, "wrap status0");
    rd(2'd1, 32'd1, "wrap count");
    rd(2'd3, 32'd0, "wrap status1");
    rd(2'd3, 32'd0, "wrap status2");
    rd(2'd3, 32'd1, "wrap status3");
    rd(2'd1, 32'd9, "wrap count2");
    check("wrap irq masked", {31'h0, irq}, 32'd0);

    // PRESCALE=4, no reload
    wr(2'd0, 32'd0); wr(2'd2, 32'd2); wr(2'd1, 32'd0); wr(2'd3, 32'd1); wr(2'd0, 32'h401);
    rd(2'd1, 32'd0, "ps4 count0");
    repeat (10) @(negedge clk);
    rd(2'd1, 32'd2, "ps4 count2");
    rd(2'd3, 32'd1, "ps4 match");
    rd(2'd1, 32'd3, "ps4 count3");

    // COUNT write on a tick edge wins over the increment
    wr(2'd0, 32'd0); wr(2'd0, 32'h301);
    repeat (2) @(negedge clk);
    wr(2'd1, 32'd100);
    rd(2'd1, 32'd100, "count write on tick");

    // reset during an access
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd2; bus.wdata = 32'd7;
    #2 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("reset no ready", {31'h0, bus.ready}, 32'd0);
    bus.sel = 1'b0; bus.we = 1'b0;
    reset = 1'b1;
    rd(2'd0, 32'd0, "rst ctrl");
    rd(2'd1, 32'd0, "rst count");
    rd(2'd2, 32'hFFFF_FFFF, "rst cmp");
    rd(2'd3, 32'd0, "rst status");
    check("rst irq", {31'h0, irq}, 32'd0);

    // random accesses scored cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  a = 2'($urandom_range(0, 3));
      logic        w = 1'($urandom_range(0, 1));
      logic [31:0] d;
      case (a)
        2'd0:    d = {16'h0, 8'($urandom_range(0, 3)), 5'h0, 3'($urandom_range(0, 7))};
        2'd1:    d = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom_range(0, 15);
        2'd2:    d = $urandom_range(0, 15);
        default: d = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(w, a, d, 1'b0, 32'd0, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timer_csr.md
# timer_csr

Memory-mapped timer peripheral: the bus-responder side of the free-running timer/compare function. A CPU-side initiator programs compare value, count, prescaler and mode through a simple request/ready register interface. The block counts prescaled clock ticks, latches a sticky match flag and drives a level interrupt that the initiator acknowledges with a write-1-to-clear. It sits on the processor's peripheral bus next to the other memory-mapped devices.

## Interface
- N, 32, counter/compare/data width; must be >= PW+8
- PW, 8, prescaler width
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- sel  input  1  access request; held by initiator until ready
- we  input  1  1 = write, 0 = read; valid with sel
- addr  input  2  register select: 0 CTRL, 1 COUNT, 2 CMP, 3 STATUS
- wdata  input  N  write data; valid with sel & we
- rdata  output  N  read data; valid only while ready=1
- ready  output  1  one-cycle access-complete pulse
- irq  output  1  interrupt, level = STATUS.MATCH & CTRL.IE

## Operation
- Registers:
  - CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE, bits[PW+7:8] PRESCALE; other bits read 0.
  - COUNT: current count; writable.
  - CMP: compare value.
  - STATUS: bit0 MATCH (sticky); write 1 to bit0 clears; write 0 has no effect.
- Prescaler pre (PW bits): while EN=1, pre increments each cycle. When pre==PRESCALE, a tick occurs and pre returns to 0. While EN=0, pre and COUNT hold.
- On tick:
  - If COUNT==CMP, MATCH<=1.
  - If COUNT==CMP and AR=1, COUNT<=0; otherwise COUNT<=COUNT+1, modulo 2^N (wrap from all-ones to 0, no flag from the wrap itself).
- Tick period = PRESCALE+1 cycles.
- Writing CTRL clears pre to 0.
- Writing COUNT clears pre to 0 and overrides any same-cycle tick increment or reload.
- Simultaneous MATCH set (tick) and W1C clear: set wins, MATCH stays 1.
- Writing CMP in a tick cycle: the compare uses the old CMP value.
- irq is driven combinationally from registers only; no input-to-output combinational path.
- Reset values:
  - CTRL=0, COUNT=0, CMP=all ones, pre=0, MATCH=0.
  - ready=0, rdata=0, irq=0.

## Timing
- Handshake FSM, two states:
  - IDLE: if sel=1, move to ACK. ready<=1. For reads, rdata<=selected register. For writes, the register update occurs at this same edge.
  - ACK: ready=1 for exactly one cycle, then return to IDLE with ready<=0. sel is ignored in ACK.
- Minimum access length is 2 cycles, measured from the cycle sel is first sampled high. The initiator must drop sel, or present a new access, in the cycle after ready.
- Read data reflects register state before any same-edge counter update. rdata returns to 0 when ready falls.
- Read latency is 1 cycle (rdata with ready). Write side effects are visible to a read issued the next access.
- MATCH rises at the edge ending the tick cycle. irq follows in the same cycle that MATCH=1 if IE=1.
- Mid-operation reset (reset low): all state returns to reset values immediately. An access in flight is dropped with no ready pulse.

## Test plan
- Reset, then read all four registers -> CTRL=0, COUNT=0, CMP=0xFFFFFFFF, STATUS=0, irq=0, each ready exactly 1 cycle after sel.
- Write CMP=3, CTRL=EN|AR|IE with PRESCALE=0 -> COUNT cycles 0,1,2,3,0. MATCH and irq rise 4 cycles after enable, and the sequence repeats every 4 cycles.
- PRESCALE=4, AR=0, CMP=2 -> COUNT increments every 5 cycles. MATCH sets on the tick where COUNT=2 and COUNT continues to 3.
- COUNT=0xFFFFFFFE, CMP=5, EN, PRESCALE=0 -> COUNT reaches 0xFFFFFFFF then wraps to 0. MATCH=0 until COUNT=5.
- W1C STATUS issued in the same cycle as a new match tick -> MATCH remains 1 and irq remains 1. A later W1C with no tick -> MATCH=0, irq=0.
- Write COUNT=100 coinciding with a tick -> COUNT=100 and pre=0. Assert reset mid-access -> no ready pulse and all registers back to reset values.
